serial_bus_arbiter: RTL and testbench
=====================================

# serial_bus_arbiter

- Two-initiator arbiter and sequencer for the serial bus.
- Takes bus requests from the two initiator blocks and issues at most one grant at a time.
- Drives the address/data mux select toward the targets.
- Tracks one outstanding split transaction: the split initiator is parked while the other initiator uses the bus, then re-granted with top priority when the target resumes.

## Interface
- `ROUND_ROBIN`, default 1: 1 = alternate winner on simultaneous requests; 0 = initiator 1 always wins.
- `TIMEOUT_CYCLES`, default 16'd1024: max cycles a grant is held without ack/split; 0 disables the watchdog.

Ports:
- `clk`  in  1  bus clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req1`  in  1  bus request, initiator 1.
- `req2`  in  1  bus request, initiator 2.
- `target_ack`  in  1  current transaction complete (one-cycle pulse from target).
- `target_split`  in  1  target splits current transaction (one-cycle pulse).
- `split_resume`  in  1  split target ready to return data (one-cycle pulse).
- `grant1`  out  1  bus granted to initiator 1.
- `grant2`  out  1  bus granted to initiator 2.
- `msel`  out  1  mux select: 0 = initiator 1, 1 = initiator 2.
- `busy`  out  1  high whenever a grant is active.
- `split_pending`  out  1  one initiator is parked on a split.
- `timeout`  out  1  one-cycle pulse when the watchdog revokes a grant.
- `split_err`  out  1  sticky error: split attempted while one already pending.

## Operation
- States: `S_IDLE`, `S_GRANT`, `S_RESUME`.
- Registers:
  - `owner` (1 bit) and `last_owner`.
  - `split_owner` and `split_pending`.
  - `resume_latched`.
  - 16-bit watchdog counter `wd`.
- `S_IDLE`, evaluated in priority order:
  - `split_pending` and (`split_resume` or `resume_latched`): `owner` <= `split_owner`, clear `resume_latched`, go to `S_RESUME`.
  - Else arbitrate among eligible requests. An initiator is eligible if its req is high and it is not `split_owner` while `split_pending`.
    - One eligible request: it wins.
    - Both eligible: with `ROUND_ROBIN`=1 the winner is the one that is not `last_owner`; with 0, initiator 1 wins.
  - On a winner: `owner`/`last_owner` <= winner, go to `S_GRANT`.
  - No winner: stay in `S_IDLE`.
- `S_GRANT`: grant[owner]=1. Exit to `S_IDLE` on the first of these, checked in order:
  - `target_ack`.
  - `target_split`:
    - If `split_pending`=0: set `split_pending`, `split_owner` <= `owner`.
    - Else: set `split_err` and release; the transaction is dropped.
  - req[owner] deasserted while no ack/split has arrived.
  - Watchdog expiry: pulse `timeout`.
- `S_RESUME`: grant[split_owner]=1, regardless of that initiator's req.
  - `target_ack`: clear `split_pending`, go to `S_IDLE`.
  - Watchdog expiry: clear `split_pending`, pulse `timeout`, go to `S_IDLE`.
  - `target_split` here sets `split_err` and releases.
- `split_resume` arriving in any state other than `S_IDLE` while `split_pending`: set `resume_latched`.
- `split_resume` with no split pending: ignored.
- Watchdog:
  - `wd` clears on entry to `S_GRANT`/`S_RESUME` and increments each granted cycle.
  - Expiry when `wd` == `TIMEOUT_CYCLES`-1 and no ack/split that cycle. Ack wins on the same cycle.
- `grant1` and `grant2` are never high together. `msel` = `owner` while granted and holds its last value in `S_IDLE`.

## Timing
- All outputs are registered.
- Reset (async, immediate):
  - `grant1`=`grant2`=0, `msel`=0, `busy`=0, `split_pending`=0, `timeout`=0, `split_err`=0.
  - State `S_IDLE`, `last_owner`=1 so the first tie goes to initiator 1.
  - `wd`=0, `resume_latched`=0.
  - Reset mid-transaction drops the grant and any pending split with no further pulses.
- Grant latency: req sampled high in cycle N in `S_IDLE` -> grant high in N+1.
- Release: ack/split/req-drop/expiry sampled in cycle M -> grant low in M+1.
- Turnaround: `S_IDLE` lasts at least one cycle, so the next grant is earliest at M+2.
- Resume latency: `split_resume` in cycle N with bus idle -> grant[split_owner] in N+1.
- `timeout` is high for exactly the cycle in which the grant drops.
- Simultaneous `target_ack` and `target_split`: ack wins and no split is recorded.
- `split_pending` updates in the same cycle the grant drops.

## Test plan
- Single request: `req1`=1 at cycle 2 -> `grant1`=1, `msel`=0 from cycle 3; `target_ack` at cycle 6 -> `grant1`=0 at cycle 7, `busy`=0.
- Tie: `req1`=`req2`=1 continuously, ack every 4th granted cycle, `ROUND_ROBIN`=1 -> grants alternate 1,2,1,2. With `ROUND_ROBIN`=0 -> only initiator 1 is granted.
- Split: initiator 1 granted, `target_split` -> `split_pending`=1, `grant1` drops. `req2`=1 -> `grant2` with `msel`=1. `split_resume` during the `grant2` hold, then ack -> `grant1` re-granted 2 cycles after that ack while `req1`=0; next ack clears `split_pending`.
- Watchdog: `TIMEOUT_CYCLES`=8, `req2` held with no ack -> `grant2` high for exactly 8 cycles, `timeout` pulses once on the cycle the grant drops.
- Double split: `split_pending`=1, other initiator granted, `target_split` -> `split_err`=1 (sticky), `split_pending` and `split_owner` unchanged.
- Async reset asserted mid-grant -> all outputs 0 immediately; after release `req2` alone -> `grant2` one cycle later.

Source files
------------

// File: rtl/serial_bus_arbiter_if.sv
// Serial bus arbiter handshake bundle.
// Carries the two initiator requests, the target completion/split/resume
// pulses, and the arbiter's grant, mux-select and status outputs.
//   master : arbiter side (drives grants/status, reads requests/target pulses)
//   slave  : bus side (drives requests/target pulses, reads grants/status)
interface serial_bus_arbiter_if;
    logic req1;
    logic req2;
    logic target_ack;
    logic target_split;
    logic split_resume;
    logic grant1;
    logic grant2;
    logic msel;
    logic busy;
    logic split_pending;
    logic timeout;
    logic split_err;

    modport master (
        input  req1, req2, target_ack, target_split, split_resume,
        output grant1, grant2, msel, busy, split_pending, timeout, split_err
    );

    modport slave (
        output req1, req2, target_ack, target_split, split_resume,
        input  grant1, grant2, msel, busy, split_pending, timeout, split_err
    );
endinterface

// File: rtl/serial_bus_arbiter.sv
// Two-initiator arbiter/sequencer for the serial bus with one tracked split.
// Ports:
//   clk  - bus clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - serial_bus_arbiter_if.master: req1/req2, target_ack/split/resume in;
//          grant1/grant2, msel, busy, split_pending, timeout, split_err out
// owner encoding: 0 = initiator 1, 1 = initiator 2 (matches msel).
module serial_bus_arbiter #(
    parameter bit          ROUND_ROBIN    = 1'b1,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_bus_arbiter_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RESUME} state_t;

    state_t      state, state_nxt;
    logic        owner, owner_nxt;
    logic        last_owner, last_owner_nxt;
    logic        split_owner, split_owner_nxt;
    logic        split_pend, split_pend_nxt;
    logic        resume_latched, resume_latched_nxt;
    logic        split_err, split_err_nxt;
    logic        timeout, timeout_nxt;
    logic [15:0] wd, wd_nxt;
    logic        grant1, grant2, busy;

    logic        expire;
    logic        req_owner;
    logic        elig1, elig2;
    logic        win;

    // A TIMEOUT_CYCLES of zero disables the watchdog entirely.
    assign expire    = (TIMEOUT_CYCLES != 16'd0) && (wd == TIMEOUT_CYCLES - 16'd1);
    assign req_owner = owner ? bus.req2 : bus.req1;
    // The parked split initiator may not re-arbitrate; it only returns via resume.
    assign elig1     = bus.req1 && !(split_pend && !split_owner);
    assign elig2     = bus.req2 && !(split_pend &&  split_owner);

    always_comb begin
        state_nxt          = state;
        owner_nxt          = owner;
        last_owner_nxt     = last_owner;
        split_owner_nxt    = split_owner;
        split_pend_nxt     = split_pend;
        resume_latched_nxt = resume_latched;
        split_err_nxt      = split_err;
        timeout_nxt        = 1'b0;
        wd_nxt             = wd + 16'd1;
        win                = 1'b0;

        case (state)
            S_IDLE: begin
                // Idle always precedes a grant, so clearing here gives a fresh count on entry.
                wd_nxt = 16'd0;
                if (split_pend && (bus.split_resume || resume_latched)) begin
                    owner_nxt          = split_owner;
                    resume_latched_nxt = 1'b0;
                    state_nxt          = S_RESUME;
                end else if (elig1 || elig2) begin
                    if (elig1 && elig2)
                        win = ROUND_ROBIN ? ~last_owner : 1'b0;
                    else
                        win = elig2;
                    owner_nxt      = win;
                    last_owner_nxt = win;
                    state_nxt      = S_GRANT;
                end
            end
            S_GRANT: begin
                if (bus.target_ack) begin
                    state_nxt = S_IDLE;
                end else if (bus.target_split) begin
                    if (!split_pend) begin
                        split_pend_nxt  = 1'b1;
                        split_owner_nxt = owner;
                    end else begin
                        split_err_nxt = 1'b1;
                    end
                    state_nxt = S_IDLE;
                end else if (!req_owner) begin
                    state_nxt = S_IDLE;
                end else if (expire) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_RESUME: begin
                // Resumed owner holds the bus regardless of its request line.
                if (bus.target_ack) begin
                    split_pend_nxt = 1'b0;
                    state_nxt      = S_IDLE;
                end else if (bus.target_split) begin
                    split_err_nxt = 1'b1;
                    state_nxt     = S_IDLE;
                end else if (expire) begin
                    split_pend_nxt = 1'b0;
                    timeout_nxt    = 1'b1;
                    state_nxt      = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Resume arriving while the bus is busy is remembered for the next idle cycle.
        if (state != S_IDLE && split_pend && bus.split_resume)
            resume_latched_nxt = 1'b1;
        // A stale latch must not outlive the split it belongs to.
        if (!split_pend_nxt)
            resume_latched_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            owner          <= 1'b0;
            last_owner     <= 1'b1;
            split_owner    <= 1'b0;
            split_pend     <= 1'b0;
            resume_latched <= 1'b0;
            split_err      <= 1'b0;
            timeout        <= 1'b0;
            wd             <= 16'd0;
            grant1         <= 1'b0;
            grant2         <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_nxt;
            owner          <= owner_nxt;
            last_owner     <= last_owner_nxt;
            split_owner    <= split_owner_nxt;
            split_pend     <= split_pend_nxt;
            resume_latched <= resume_latched_nxt;
            split_err      <= split_err_nxt;
            timeout        <= timeout_nxt;
            wd             <= wd_nxt;
            grant1         <= (state_nxt != S_IDLE) && !owner_nxt;
            grant2         <= (state_nxt != S_IDLE) &&  owner_nxt;
            busy           <= (state_nxt != S_IDLE);
        end
    end

    // owner only changes when a grant starts, so it doubles as the held mux select.
    assign bus.grant1        = grant1;
    assign bus.grant2        = grant2;
    assign bus.msel          = owner;
    assign bus.busy          = busy;
    assign bus.split_pending = split_pend;
    assign bus.timeout       = timeout;
    assign bus.split_err     = split_err;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Scoreboard bench for serial_bus_arbiter.
// dut_a: round robin, 8-cycle watchdog. dut_b: fixed priority, default watchdog.
// Output vector order: {grant1, grant2, msel, busy, split_pending, timeout, split_err}.
module tb_serial_bus_arbiter;

    logic clk;
    logic rst;

    serial_bus_arbiter_if bus_a ();
    serial_bus_arbiter_if bus_b ();

    serial_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT_CYCLES(16'd8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    serial_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT_CYCLES(16'd1024)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] va, vb;
    assign va = {bus_a.grant1, bus_a.grant2, bus_a.msel, bus_a.busy,
                 bus_a.split_pending, bus_a.timeout, bus_a.split_err};
    assign vb = {bus_b.grant1, bus_b.grant2, bus_b.msel, bus_b.busy,
                 bus_b.split_pending, bus_b.timeout, bus_b.split_err};

    typedef struct {
        string      tag;
        bit         sel;
        logic [6:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus_a.req1 = 0; bus_a.req2 = 0; bus_a.target_ack = 0;
        bus_a.target_split = 0; bus_a.split_resume = 0;
        bus_b.req1 = 0; bus_b.req2 = 0; bus_b.target_ack = 0;
        bus_b.target_split = 0; bus_b.split_resume = 0;
    endtask

    // Drive one cycle of inputs on the selected DUT and queue the outputs
    // expected right after the edge that samples them.
    task automatic step(input bit sel, input logic r1, input logic r2, input logic ack,
                        input logic spl, input logic res, input logic [6:0] exp,
                        input string tag);
        exp_t e;
        @(negedge clk);
        clear_inputs();
        if (!sel) begin
            bus_a.req1 = r1; bus_a.req2 = r2; bus_a.target_ack = ack;
            bus_a.target_split = spl; bus_a.split_resume = res;
        end else begin
            bus_b.req1 = r1; bus_b.req2 = r2; bus_b.target_ack = ack;
            bus_b.target_split = spl; bus_b.split_resume = res;
        end
        e.tag = tag; e.sel = sel; e.exp = exp;
        sb.push_back(e);
    endtask

    // Assert reset between clock edges and check the outputs drop at once.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        clear_inputs();
        rst = 1'b1;
        #1;
        chk({tag, "_a"}, va, 7'b0);
        chk({tag, "_b"}, vb, 7'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, mon_e.sel ? vb : va, mon_e.exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL tb_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        do_reset("rst_init");

        // Single request, release on ack, msel holds.
        step(0, 1, 0, 0, 0, 0, 7'b1001000, "single_g");
        step(0, 1, 0, 0, 0, 0, 7'b1001000, "single_g");
        step(0, 1, 0, 0, 0, 0, 7'b1001000, "single_g");
        step(0, 1, 0, 1, 0, 0, 7'b0000000, "single_ack");
        step(0, 0, 0, 0, 0, 0, 7'b0000000, "single_idle");

        // Tie with round robin: 1,2,1,2, ack on 4th granted cycle.
        do_reset("rst_rr");
        for (int r = 0; r < 4; r++) begin
            logic [6:0] g, id;
            g  = (r % 2 == 0) ? 7'b1001000 : 7'b0111000;
            id = (r % 2 == 0) ? 7'b0000000 : 7'b0010000;
            step(0, 1, 1, 0, 0, 0, g, "rr_g");
            for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0, 0, g, "rr_hold");
            step(0, 1, 1, 1, 0, 0, id, "rr_rel");
        end

        // Tie with fixed priority: initiator 1 every time.
        for (int r = 0; r < 3; r++) begin
            step(1, 1, 1, 0, 0, 0, 7'b1001000, "fix_g");
            for (int k = 0; k < 3; k++) step(1, 1, 1, 0, 0, 0, 7'b1001000, "fix_hold");
            step(1, 1, 1, 1, 0, 0, 7'b0000000, "fix_rel");
        end

        // Split, other initiator uses the bus, resume latched, re-grant.
        do_reset("rst_split");
        step(0, 1, 0, 0, 0, 0, 7'b1001000, "sp_g1");
        step(0, 1, 0, 0, 0, 0, 7'b1001000, "sp_g1");
        step(0, 1, 0, 0, 1, 0, 7'b0000100, "sp_split");
        step(0, 0, 1, 0, 0, 0, 7'b0111100, "sp_g2");
        step(0, 0, 1, 0, 0, 0, 7'b0111100, "sp_g2");
        step(0, 0, 1, 0, 0, 1, 7'b0111100, "sp_res_busy");
        step(0, 0, 1, 0, 0, 0, 7'b0111100, "sp_g2");
        step(0, 0, 1, 1, 0, 0, 7'b0010100, "sp_ack2");
        step(0, 0, 1, 0, 0, 0, 7'b1001100, "sp_resume_g1");
        step(0, 0, 1, 0, 0, 0, 7'b1001100, "sp_resume_hold");
        step(0, 0, 0, 1, 0, 0, 7'b0000000, "sp_resume_ack");
        step(0, 0, 0, 0, 0, 1, 7'b0000000, "sp_res_ignored");

        // Double split: error is sticky, pending split and its owner are kept.
        step(0, 1, 0, 0, 0, 0, 7'b1001000, "ds_g1");
        step(0, 1, 0, 0, 1, 0, 7'b0000100, "ds_split1");
        step(0, 0, 1, 0, 0, 0, 7'b0111100, "ds_g2");
        step(0, 0, 1, 0, 1, 0, 7'b0010101, "ds_split2");
        step(0, 1, 1, 0, 0, 0, 7'b0111101, "ds_parked");
        step(0, 0, 1, 1, 0, 0, 7'b0010101, "ds_ack2");
        step(0, 0, 0, 0, 0, 1, 7'b1001101, "ds_resume_g1");
        step(0, 0, 0, 1, 0, 0, 7'b0000001, "ds_resume_ack");
        step(0, 0, 0, 0, 0, 0, 7'b0000001, "ds_err_sticky");

        // Watchdog: 8 granted cycles then a single timeout pulse.
        do_reset("rst_wd");
        for (int k = 0; k < 8; k++) step(0, 0, 1, 0, 0, 0, 7'b0111000, "wd_g2");
        step(0, 0, 1, 0, 0, 0, 7'b0010010, "wd_expire");
        step(0, 0, 0, 0, 0, 0, 7'b0010000, "wd_pulse_end");

        // Async reset mid-grant, then a fresh grant one cycle after request.
        step(0, 1, 0, 0, 0, 0, 7'b1001000, "mr_g1");
        step(0, 1, 0, 0, 0, 0, 7'b1001000, "mr_g1");
        do_reset("rst_mid");
        step(0, 0, 1, 0, 0, 0, 7'b0111000, "mr_g2");
        step(0, 0, 1, 1, 0, 0, 7'b0010000, "mr_ack");

        @(posedge clk);
        #3;
        chk("sb_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
